cla_rr_sched: RTL and testbench
===============================

Name: cla_rr_sched

Overview:
- Round-robin scheduler that shares one clocked carry-lookahead adder datapath between two requesters.
- Each grant captures the winning requester's operands and drives them to the adder for LAT cycles. It then captures sum/carry and returns them with a one-cycle done pulse tagged with the requester ID.
- Sits between client blocks (accumulators, counters) and the single adder instance, so clients never drive the adder directly.

Parameters:
- WIDTH, 32, operand/sum width in bits (4..32).
- LAT, 1, clock cycles the adder needs after operands are presented before add_s/add_co are valid (1..4).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 request; held high until gnt0.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- ci0  input  1  requester 0 carry-in.
- req1  input  1  requester 1 request.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- ci1  input  1  requester 1 carry-in.
- gnt0  output  1  one-cycle pulse: requester 0's operands captured.
- gnt1  output  1  one-cycle pulse: requester 1's operands captured.
- add_a  output  WIDTH  registered operand A to adder.
- add_b  output  WIDTH  registered operand B to adder.
- add_ci  output  1  registered carry-in to adder.
- add_s  input  WIDTH  adder sum.
- add_co  input  1  adder carry-out.
- s_out  output  WIDTH  registered result sum.
- co_out  output  1  registered result carry.
- done  output  1  one-cycle pulse: s_out/co_out valid.
- done_id  output  1  requester served by the current result (0/1).
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, ptr=0, cnt=0. All outputs 0: gnt0/1, add_a/b/ci, s_out, co_out, done, done_id, busy.
- Reset mid-operation aborts the operation silently: no done pulse and no grant replay. The requester must re-request.
- FSM has 3 states: IDLE, RUN, DONE.
- IDLE:
  - If neither req is high, remain in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester indicated by ptr (ptr=0 favours req0).
  - On the grant edge: pulse gnt for 1 cycle, register a/b/ci into add_a/add_b/add_ci, latch id, load cnt=LAT-1, go to RUN.
- RUN:
  - add_* stay stable.
  - If cnt==0, capture add_s into s_out and add_co into co_out, set done_id=id, go to DONE. Otherwise cnt decrements.
- DONE:
  - done=1 for exactly 1 cycle. Set ptr = ~id, so the other requester gets priority next. Go to IDLE.
  - s_out/co_out/done_id hold until the next capture. add_* hold their last values.
- Timing: a grant at edge T produces the result capture at edge T+LAT and done high during cycle T+LAT+1.
- Throughput: one operation per LAT+2 cycles.
- Handshake rules:
  - Operands are sampled only on the grant edge; later changes to a/b/ci are ignored.
  - A req dropped before its grant is simply never served. This is legal.
  - A req still high in the IDLE cycle after DONE counts as a new request.
  - Requests arriving during RUN/DONE wait; no queueing beyond the level-held req.
- Simultaneous events: with both req held continuously, grants strictly alternate 0,1,0,1. A requester is never granted twice in a row while the other waits.
- Arithmetic: the scheduler performs none; s_out/co_out are exactly the adder's output. Carry-out equals bit WIDTH of a+b+ci. Wrap-around of s_out is modulo 2^WIDTH.
- gnt0 and gnt1 are never high together. gnt and done are never high in the same cycle.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - default WIDTH/LAT constants.
- One natural sub-module: rr_arb2. Purely combinational 2-way round-robin pick from req0, req1, ptr; outputs gnt_vec[1:0] and win_id.
- The FSM, counter and operand/result registers stay in cla_rr_sched.
- The adder itself is external, connected via add_*.

Test Plan:
- Reset, then idle -> all outputs 0, busy=0, no gnt for 10 cycles with req0=req1=0.
- req0 only; a0=32'h0000_0005, b0=32'h0000_0003, ci0=1; LAT=1 with a combinational adder model -> gnt0 pulse at T, done at T+2 with s_out=32'h0000_0009, co_out=0, done_id=0.
- req1 only; a1=32'hFFFF_FFFF, b1=32'h0000_0001, ci1=0 -> s_out=32'h0000_0000, co_out=1, done_id=1 (wrap-around).
- req0 and req1 held high for 4 operations -> grant order 0,1,0,1; done_id order 0,1,0,1; no overlap of gnt/done.
- LAT=3 parameter run; change a0 after gnt0 -> done exactly 4 cycles after gnt0. Result uses the captured operands, not the changed ones.
- Assert reset_n low during RUN -> all outputs 0 immediately, no done pulse. After release with req1 high, the first grant is gnt1 and ptr restarts at 0.

Source files
------------

// File: rtl/cla_rr_sched_pkg.sv
// Shared types and defaults for the round-robin adder scheduler.
package cla_rr_sched_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_LAT   = 1;
  localparam int unsigned CNT_W     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cla_rr_sched_rr_arb2.sv
// Two-way round-robin pick; ptr selects the winner only when both request.
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  output logic [1:0] gnt_vec,
  output logic       win_id
);

  always_comb begin
    gnt_vec = 2'b00;
    win_id  = 1'b0;
    if (req0 && req1) begin
      win_id = ptr;
    end else begin
      win_id = req1;
    end
    if (req0 || req1) begin
      gnt_vec = win_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/cla_rr_sched.sv
// Shares one external clocked adder between two requesters, round-robin,
// one operation per LAT+2 cycles with a tagged done pulse per result.
module cla_rr_sched
  import cla_rr_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LAT   = DEF_LAT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             ci0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             ci1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  output logic [WIDTH-1:0] s_out,
  output logic             co_out,
  output logic             done,
  output logic             done_id,
  output logic             busy
);

  state_t           state, state_d;
  logic             ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             id, id_d;
  logic             gnt0_d, gnt1_d;
  logic [WIDTH-1:0] add_a_d, add_b_d, s_out_d;
  logic             add_ci_d, co_out_d, done_d, done_id_d, busy_d;
  logic [1:0]       gnt_vec;
  logic             win_id;

  rr_arb2 u_arb (
    .req0    (req0),
    .req1    (req1),
    .ptr     (ptr),
    .gnt_vec (gnt_vec),
    .win_id  (win_id)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    cnt_d     = cnt;
    id_d      = id;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    add_a_d   = add_a;
    add_b_d   = add_b;
    add_ci_d  = add_ci;
    s_out_d   = s_out;
    co_out_d  = co_out;
    done_id_d = done_id;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vec != 2'b00) begin
          gnt0_d   = gnt_vec[0];
          gnt1_d   = gnt_vec[1];
          add_a_d  = win_id ? a1  : a0;
          add_b_d  = win_id ? b1  : b0;
          add_ci_d = win_id ? ci1 : ci0;
          id_d     = win_id;
          cnt_d    = CNT_W'(LAT - 1);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          s_out_d   = add_s;
          co_out_d  = add_co;
          done_id_d = id;
          state_d   = DONE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        ptr_d   = ~id;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr     <= 1'b0;
      cnt     <= '0;
      id      <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_ci  <= 1'b0;
      s_out   <= '0;
      co_out  <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ptr     <= ptr_d;
      cnt     <= cnt_d;
      id      <= id_d;
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      add_a   <= add_a_d;
      add_b   <= add_b_d;
      add_ci  <= add_ci_d;
      s_out   <= s_out_d;
      co_out  <= co_out_d;
      done    <= done_d;
      done_id <= done_id_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_cla_rr_sched.sv
// Scoreboard bench for cla_rr_sched: a LAT=1 and a LAT=3 instance, each with
// a combinational adder model on its add_* port.
module tb_cla_rr_sched;

  localparam int unsigned W    = 32;
  localparam int unsigned W1   = W + 1;
  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;

  typedef struct packed {
    logic         id;
    logic         co;
    logic [W-1:0] s;
  } exp_res_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         req0 [2], req1 [2], ci0 [2], ci1 [2];
  logic [W-1:0] a0 [2], b0 [2], a1 [2], b1 [2];
  logic         gnt0 [2], gnt1 [2], add_ci [2], add_co [2];
  logic         co_out [2], done [2], done_id [2], busy [2];
  logic [W-1:0] add_a [2], add_b [2], add_s [2], s_out [2];

  cla_rr_sched #(.WIDTH(W), .LAT(LAT0)) u_lat1 (
    .clk(clk), .reset_n(reset_n),
    .req0(req0[0]), .a0(a0[0]), .b0(b0[0]), .ci0(ci0[0]),
    .req1(req1[0]), .a1(a1[0]), .b1(b1[0]), .ci1(ci1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]),
    .add_a(add_a[0]), .add_b(add_b[0]), .add_ci(add_ci[0]),
    .add_s(add_s[0]), .add_co(add_co[0]),
    .s_out(s_out[0]), .co_out(co_out[0]), .done(done[0]),
    .done_id(done_id[0]), .busy(busy[0])
  );

  cla_rr_sched #(.WIDTH(W), .LAT(LAT1)) u_lat3 (
    .clk(clk), .reset_n(reset_n),
    .req0(req0[1]), .a0(a0[1]), .b0(b0[1]), .ci0(ci0[1]),
    .req1(req1[1]), .a1(a1[1]), .b1(b1[1]), .ci1(ci1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]),
    .add_a(add_a[1]), .add_b(add_b[1]), .add_ci(add_ci[1]),
    .add_s(add_s[1]), .add_co(add_co[1]),
    .s_out(s_out[1]), .co_out(co_out[1]), .done(done[1]),
    .done_id(done_id[1]), .busy(busy[1])
  );

  assign {add_co[0], add_s[0]} = W1'(add_a[0]) + W1'(add_b[0]) + W1'(add_ci[0]);
  assign {add_co[1], add_s[1]} = W1'(add_a[1]) + W1'(add_b[1]) + W1'(add_ci[1]);

  int       checks = 0;
  int       errors = 0;
  int       cyc    = 0;
  int       gcyc [2];
  bit       q_gnt0 [$];
  bit       q_gnt1 [$];
  exp_res_t q_res0 [$];
  exp_res_t q_res1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  function automatic exp_res_t mk(input logic id, input logic co, input logic [W-1:0] s);
    exp_res_t e;
    e.id = id;
    e.co = co;
    e.s  = s;
    return e;
  endfunction

  // All control bits and OR-reduced data buses of instance k.
  function automatic logic [63:0] outs(input int k);
    return 64'({gnt0[k], gnt1[k], done[k], busy[k], add_ci[k], co_out[k],
                done_id[k], |add_a[k], |add_b[k], |s_out[k]});
  endfunction

  // Monitor: pops expectations whenever an instance shows a grant or a result.
  task automatic mon(input int k);
    bit       g;
    exp_res_t e;
    int       lat;
    lat = (k == 0) ? int'(LAT0) : int'(LAT1);
    if (gnt0[k] || gnt1[k] || done[k]) begin
      check($sformatf("excl%0d", k),
            64'({gnt0[k] & gnt1[k], (gnt0[k] | gnt1[k]) & done[k]}), 64'(0));
    end
    if (gnt0[k] || gnt1[k]) begin
      if ((k == 0 ? q_gnt0.size() : q_gnt1.size()) == 0) begin
        flag($sformatf("grant%0d", k), "got an unexpected grant, required none");
      end else begin
        g = (k == 0) ? q_gnt0.pop_front() : q_gnt1.pop_front();
        check($sformatf("grant_id%0d", k), 64'(gnt1[k]), 64'(g));
      end
      gcyc[k] = cyc;
    end
    if (done[k]) begin
      if ((k == 0 ? q_res0.size() : q_res1.size()) == 0) begin
        flag($sformatf("done%0d", k), "got an unexpected done pulse, required none");
      end else begin
        e = (k == 0) ? q_res0.pop_front() : q_res1.pop_front();
        check($sformatf("result%0d", k),
              64'({done_id[k], co_out[k], s_out[k]}), 64'(e));
        check($sformatf("latency%0d", k), 64'(cyc - gcyc[k]), 64'(lat + 1));
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic wait_gnt(input int k, input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < 100) begin
      @(negedge clk);
      budget++;
      if (gnt0[k] || gnt1[k]) seen++;
    end
    if (seen < n) flag($sformatf("wait_gnt%0d", k), $sformatf("got %0d grants, required %0d", seen, n));
  endtask

  task automatic wait_drain(input int k);
    int budget = 0;
    bit empty;
    empty = 1'b0;
    while (!empty && budget < 100) begin
      @(negedge clk);
      budget++;
      empty = (k == 0) ? (q_gnt0.size() == 0 && q_res0.size() == 0)
                       : (q_gnt1.size() == 0 && q_res1.size() == 0);
      empty = empty && !busy[k];
    end
    if (!empty) flag($sformatf("drain%0d", k), "pending expectations never served, required none");
  endtask

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1'b0; req1[k] = 1'b0; ci0[k] = 1'b0; ci1[k] = 1'b0;
      a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_outs0", outs(0), 64'(0));
    check("reset_outs1", outs(1), 64'(0));
    reset_n = 1'b1;

    // Idle with no requests: nothing moves.
    repeat (10) begin
      @(negedge clk);
      check("idle_outs0", outs(0), 64'(0));
      check("idle_outs1", outs(1), 64'(0));
    end

    // req0 alone: 5 + 3 + 1 = 9.
    a0[0] = 32'h0000_0005; b0[0] = 32'h0000_0003; ci0[0] = 1'b1;
    q_gnt0.push_back(1'b0);
    q_res0.push_back(mk(1'b0, 1'b0, 32'h0000_0009));
    req0[0] = 1'b1;
    wait_gnt(0, 1);
    req0[0] = 1'b0;
    wait_drain(0);

    // req1 alone: FFFFFFFF + 1 wraps to 0 with carry out.
    a1[0] = 32'hFFFF_FFFF; b1[0] = 32'h0000_0001; ci1[0] = 1'b0;
    q_gnt0.push_back(1'b1);
    q_res0.push_back(mk(1'b1, 1'b1, 32'h0000_0000));
    req1[0] = 1'b1;
    wait_gnt(0, 1);
    req1[0] = 1'b0;
    wait_drain(0);

    // Both held: strict alternation 0,1,0,1 (10+20=30, 100+200+1=301).
    a0[0] = 32'd10;  b0[0] = 32'd20;  ci0[0] = 1'b0;
    a1[0] = 32'd100; b1[0] = 32'd200; ci1[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q_gnt0.push_back(1'b0);
      q_res0.push_back(mk(1'b0, 1'b0, 32'd30));
      q_gnt0.push_back(1'b1);
      q_res0.push_back(mk(1'b1, 1'b0, 32'd301));
    end
    req0[0] = 1'b1; req1[0] = 1'b1;
    wait_gnt(0, 4);
    req0[0] = 1'b0; req1[0] = 1'b0;
    wait_drain(0);

    // One more req0 op leaves ptr favouring requester 1.
    q_gnt0.push_back(1'b0);
    q_res0.push_back(mk(1'b0, 1'b0, 32'd30));
    req0[0] = 1'b1;
    wait_gnt(0, 1);
    req0[0] = 1'b0;
    wait_drain(0);

    // LAT=3: operands change after the grant and must be ignored.
    a0[1] = 32'h0000_1234; b0[1] = 32'h0000_0001; ci0[1] = 1'b0;
    q_gnt1.push_back(1'b0);
    q_res1.push_back(mk(1'b0, 1'b0, 32'h0000_1235));
    req0[1] = 1'b1;
    wait_gnt(1, 1);
    req0[1] = 1'b0;
    a0[1] = 32'hFFFF_0000;
    wait_drain(1);

    // Reset during RUN aborts the LAT=3 op with no done pulse.
    a0[1] = 32'h0000_0055; b0[1] = 32'h0000_0011;
    q_gnt1.push_back(1'b0);
    req0[1] = 1'b1;
    wait_gnt(1, 1);
    req0[1] = 1'b0;
    @(negedge clk);
    check("run_busy1", 64'(busy[1]), 64'(1));
    reset_n = 1'b0;
    #1;
    check("abort_outs0", outs(0), 64'(0));
    check("abort_outs1", outs(1), 64'(0));

    // After release: req1 alone wins on LAT=3 (7+8=15); on LAT=1 both
    // request and requester 0 wins, showing ptr was cleared.
    a1[1] = 32'd7; b1[1] = 32'd8; ci1[1] = 1'b0;
    q_gnt1.push_back(1'b1);
    q_res1.push_back(mk(1'b1, 1'b0, 32'd15));
    req1[1] = 1'b1;
    q_gnt0.push_back(1'b0);
    q_res0.push_back(mk(1'b0, 1'b0, 32'd30));
    req0[0] = 1'b1; req1[0] = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    fork
      begin wait_gnt(0, 1); req0[0] = 1'b0; req1[0] = 1'b0; end
      begin wait_gnt(1, 1); req1[1] = 1'b0; end
    join
    wait_drain(0);
    wait_drain(1);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
